// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default widths and the
// register addresses decoded by the APB-to-SPI slave bridge.
package apb_pkg;

   localparam int unsigned APB_ADDR_W      = 16;
   localparam int unsigned APB_DATA_W      = 32;
   localparam int unsigned APB_TIMEOUT_CYC = 255;

   // Register map of the APB-to-SPI bridge
   localparam int unsigned DATA_ADDR = 1;
   localparam int unsigned CMD_ADDR  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_requester.sv
// APB3 requester: converts a valid/ready command into one APB transfer and
// returns read data / error status on a held response interface.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase that waits
// TIMEOUT_CYC cycles without pready.
module apb_requester
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = APB_ADDR_W,
   parameter int unsigned DATA_W      = APB_DATA_W,
   parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   apb_state_e        state_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic              req_fire;

   // A new command is taken only once the previous response has been consumed
   assign req_ready   = (state_q == IDLE) && !rsp_valid_q;
   assign req_fire    = req_valid && req_ready;
   assign rsp_rdata_d = pwrite_q ? '0 : prdata;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout_hit;

   // The limit is hit on the ACCESS cycle whose increment would reach TIMEOUT_CYC
   assign timeout_hit = (wait_cnt_q == CNT_LAST);
`endif

   // Transfer FSM with registered APB and response outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q  <= '0;
`endif
      end else begin
         if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (req_fire) begin
                  pwrite_q <= req_write;
                  paddr_q  <= req_addr;
                  pwdata_q <= req_wdata;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= pslverr;
                  rsp_rdata_q <= rsp_rdata_d;
                  state_q     <= IDLE;
`ifdef APB_TIMEOUT_EN
               end else if (timeout_hit) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_ONE;
`endif
               end
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: transaction-level reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_apb_requester;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic          pready, pslverr;

   int n_cmp = 0;
   int n_bad = 0;
   int ncyc  = 0;
   bit chk_en = 1'b0;

   apb_requester #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   // Reference model: a transfer is "busy" from acceptance until the slave
   // answers; m_age counts cycles since acceptance (0 = setup, >=1 = access).
   bit            m_busy, m_write, m_rv, m_err, m_acc;
   int            m_age;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 0; m_age <= 0; m_write <= 0; m_addr <= '0; m_wdata <= '0;
         m_rv <= 0; m_rdata <= '0; m_err <= 0; m_acc <= 0;
      end else begin
         m_acc <= 0;
         if (m_rv && rsp_ready) m_rv <= 0;
         if (m_busy) begin
            if (m_age >= 1 && pready) begin
               m_busy  <= 0;
               m_rv    <= 1;
               m_err   <= pslverr;
               m_rdata <= m_write ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
            end else if (m_age == TO) begin
               m_busy  <= 0;
               m_rv    <= 1;
               m_err   <= 1;
               m_rdata <= '0;
`endif
            end else begin
               m_age <= m_age + 1;
            end
         end else if (!m_rv && req_valid) begin
            m_busy  <= 1;
            m_age   <= 0;
            m_acc   <= 1;
            m_write <= req_write;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
         end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (rst && chk_en)
         chk("cycle",
             {req_ready, psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata},
             {(!m_busy && !m_rv), m_busy, (m_busy && m_age >= 1), m_write, m_rv, m_err,
              m_addr, m_wdata, m_rdata});
   end

   // One transfer; slave answers on the (waits+1)-th access cycle.
   // Returns access-cycle count and offsets of penable / rsp_valid from psel rise.
   task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int waits, input logic [DW-1:0] rd, input bit err,
                       output int pen, output int dpen, output int drv);
      int tps;
      bit seen;
      pen = 0; dpen = -1; drv = -1; tps = -1; seen = 0;
      req_valid = 1; req_write = w; req_addr = a; req_wdata = wd;
      pready  = (waits == 0);
      prdata  = (waits == 0) ? rd : $urandom;
      pslverr = (waits == 0) ? err : 1'($urandom_range(0, 1));
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (m_acc) req_valid = 0;
         if (psel && tps < 0) tps = ncyc;
         if (penable) begin
            if (pen == 0) dpen = ncyc - tps;
            pen++;
            if (pen == waits + 1) begin pready = 1; prdata = rd; pslverr = err; end
         end
         if (rsp_valid) begin seen = 1; drv = ncyc - tps; pready = 0; pslverr = 0; end
      end
      if (!seen) chk("xfer_no_response", 0, 1);
      req_valid = 0;
   endtask

   task automatic consume();
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      int  pen, dpen, drv;
      bit  seen;
      rst = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
      rsp_ready = 0; prdata = '0; pready = 0; pslverr = 0;
      repeat (2) @(negedge clk);
      chk("reset_state", {psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata}, '0);
      chk("reset_ready", req_ready, 1);
      rst = 1;
      chk_en = 1;
      @(negedge clk);

      // Zero-wait write: penable one cycle after psel, response two cycles after
      xfer(1, 16'd2, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 0, pen, dpen, drv);
      chk("wr_timing", {8'(dpen), 8'(drv), 8'(pen)}, {8'd1, 8'd2, 8'd1});
      chk("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
      chk("wr_pwdata_held", pwdata, 32'h0000_00A5);
      consume();

      // Read with 3 wait states; with the timeout build this lands on the limit cycle
      xfer(0, 16'd1, 32'h0, 3, 32'h0000_003C, 0, pen, dpen, drv);
      chk("rd_penable_cycles", pen, 4);
      chk("rd_latency", drv, 5);
      chk("rd_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h0000_003C});
      consume();

      // Slave error on a read, then a clean write
      xfer(0, 16'd1, 32'h0, 1, 32'h0000_1234, 1, pen, dpen, drv);
      chk("err_rsp", {rsp_err, rsp_rdata}, {1'b1, 32'h0000_1234});
      consume();
      xfer(1, 16'd2, 32'h0000_0077, 2, 32'hFFFF_FFFF, 0, pen, dpen, drv);
      chk("err_cleared", {rsp_err, rsp_rdata}, {1'b0, 32'h0});

      // Response back-pressure with a waiting command (response still pending here)
      req_valid = 1; req_write = 1; req_addr = 16'd2; req_wdata = 32'h0000_0011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready_low", {req_ready, rsp_valid}, 2'b01);
      end
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      chk("bp_handshake", {rsp_valid, req_ready, psel}, 3'b010);
      @(negedge clk);
      chk("bp_second_accept", {psel, penable, pwdata}, {1'b1, 1'b0, 32'h0000_0011});
      req_valid = 0; pready = 1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      chk("bp_second_done", {seen, rsp_err}, 2'b10);
      pready = 0;
      consume();

      // Asynchronous reset in the middle of ACCESS
      req_valid = 1; req_write = 0; req_addr = 16'd1; pready = 0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (m_acc) req_valid = 0;
         seen = penable;
      end
      chk("rst_reached_access", seen, 1);
      req_valid = 0;
      #2 rst = 0;
      #1 chk("rst_async", {psel, penable, rsp_valid, req_ready}, 4'b0001);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("rst_release", {req_ready, psel, rsp_valid, paddr}, {1'b1, 1'b0, 1'b0, 16'h0});

      // Slave that never becomes ready on its own
      req_valid = 1; req_write = 0; req_addr = 16'd1; pready = 0; pslverr = 1;
      prdata = $urandom;
      pen = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (m_acc) req_valid = 0;
         if (penable) pen++;
         if (rsp_valid) seen = 1;
`ifndef APB_TIMEOUT_EN
         if (pen == 25 && !pready) begin pready = 1; prdata = 32'hCAFE_0001; pslverr = 0; end
`endif
      end
`ifdef APB_TIMEOUT_EN
      chk("timeout_cycles", pen, TO);
      chk("timeout_rsp", {seen, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
`else
      chk("stall_cycles", pen, 25);
      chk("stall_rsp", {seen, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hCAFE_0001});
`endif
      pready = 0; pslverr = 0;
      consume();

      // Randomized traffic against the model; a command is held until accepted
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if (!req_valid || m_acc) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            req_wdata = $urandom;
         end
         pready    = ($urandom_range(0, 3) != 0);
         prdata    = $urandom;
         pslverr   = 1'($urandom_range(0, 1));
         rsp_ready = ($urandom_range(0, 2) != 0);
      end

      req_valid = 0; pready = 1; rsp_ready = 1;
      repeat (10) @(negedge clk);
      chk("drain_idle", {req_ready, psel, rsp_valid}, 3'b100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
